// File: rtl/proc16_pkg.sv
// Shared constants and fetch FSM state type for the 16-bit processor.
// Latency: none, declarations only.
// Backpressure: none. FETCH_HALT_EN adds the HALT fetch state.
package proc16_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OPC_JUMP = 4'b1001;
    localparam logic [3:0] OPC_HALT = 4'hF;

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1
    } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer {word, pc, full} for a ROM word that returns while the IR is stalled.
// Latency: push/pop/flush take effect at the next rising edge.
// Backpressure: none of its own; the caller never pushes a second word into a full entry without popping.
module fetch_skid_buf
    import proc16_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int IW = INSTR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [IW-1:0] push_word_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [IW-1:0] word_o,
    output logic [AW-1:0] pc_o,
    output logic          full_o
);

    logic [IW-1:0] word_q;
    logic [AW-1:0] pc_q;
    logic          full_q;
    logic          full_d;

    // Occupancy: flush wins, a push refills even while popping, a lone pop empties.
    always_comb begin
        full_d = full_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d = 1'b1;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // Entry storage; payload only moves on push.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            word_q <= '0;
            pc_q   <= '0;
        end else begin
            full_q <= full_d;
            if (push_i) begin
                word_q <= push_word_i;
                pc_q   <= push_pc_i;
            end
        end
    end

    assign word_o = word_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous ROM, holds the IR; FETCH_HALT_EN enables halt-opcode stop.
// Latency: first IR valid 2 edges after reset release, then 1 instruction/cycle; redirect bubble is 2 cycles.
// Backpressure: ir_ready low holds the IR, stops issue and parks the single in-flight word in the skid buffer.
module instr_fetch_unit #(
    parameter int                ADDR_W   = proc16_pkg::ADDR_W,
    parameter int                INSTR_W  = proc16_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jump_take,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               halted
);

    import proc16_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    // Tracks the word issued last cycle; cleared when a redirect or halt kills it.
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic               accept, stall, redirect, halt_hit, issue;
    logic               arr_vld, ir_free, take_skid;
    logic               skid_push, skid_pop, skid_flush, skid_full;
    logic [INSTR_W-1:0] skid_word;
    logic [ADDR_W-1:0]  skid_pc;

    fetch_skid_buf #(
        .AW (ADDR_W),
        .IW (INSTR_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (skid_push),
        .push_word_i (imem_rdata),
        .push_pc_i   (inflight_pc_q),
        .pop_i       (skid_pop),
        .flush_i     (skid_flush),
        .word_o      (skid_word),
        .pc_o        (skid_pc),
        .full_o      (skid_full)
    );

    // Next-state: handshake, issue, returning-word routing and FSM transitions.
    always_comb begin
        accept   = ir_valid_q & ir_ready;
        stall    = ir_valid_q & ~ir_ready;
        redirect = accept & jump_take;
`ifdef FETCH_HALT_EN
        halt_hit = accept & (ir_q[3:0] == OPC_HALT);
        issue    = ~reset & ~stall & (state_q != HALT);
`else
        halt_hit = 1'b0;
        issue    = ~reset & ~stall;
`endif
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_flush    = 1'b0;

        if (issue) begin
            pc_d = pc_q + ADDR_W'(1);
        end
        if (accept) begin
            ir_valid_d = 1'b0;
        end

        // Words only count in RUN; anything returning in REDIR belongs to the old path.
        arr_vld   = inflight_q & (state_q == RUN);
        ir_free   = accept | ~ir_valid_q;
        take_skid = skid_full & ir_free;

        if (take_skid) begin
            ir_d       = skid_word;
            ir_pc_d    = skid_pc;
            ir_valid_d = 1'b1;
            skid_pop   = 1'b1;
            skid_push  = arr_vld;
        end else if (arr_vld) begin
            if (ir_free) begin
                ir_d       = imem_rdata;
                ir_pc_d    = inflight_pc_q;
                ir_valid_d = 1'b1;
            end else begin
                skid_push = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (halt_hit) begin
`ifdef FETCH_HALT_EN
                    state_d    = HALT;
`endif
                    ir_valid_d = 1'b0;
                    skid_flush = 1'b1;
                    inflight_d = 1'b0;
                end else if (redirect) begin
                    state_d    = REDIR;
                    pc_d       = jump_addr;
                    ir_valid_d = 1'b0;
                    skid_flush = 1'b1;
                    inflight_d = 1'b0;
                end
            end
            REDIR: begin
                state_d = RUN;
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC and IR registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
`ifdef FETCH_HALT_EN
    assign halted    = (state_q == HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule
